// File: rtl/id_ex_if.sv
// id_ex_if: decode-side inputs, EX-side registered outputs and hazard controls of the ID/EX stage
interface id_ex_if;
  logic RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, jump, shiftC;
  logic [1:0] ALUOp;
  logic [31:0] pc_plus4, read_data1, read_data2, imm_ext;
  logic [4:0] rs, rt, rd, shamt;
  logic [5:0] funcion;
  logic flush, hold;
  logic ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite, ex_jump, ex_shiftC;
  logic [1:0] ex_ALUOp;
  logic [31:0] ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm_ext;
  logic [4:0] ex_rs, ex_rt, ex_rd, ex_shamt;
  logic [5:0] ex_funcion;
  logic ctrl_enable, pc_write, if_id_write;
  logic [15:0] stall_count;
  modport master (
    output RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, jump, shiftC, ALUOp,
           pc_plus4, read_data1, read_data2, imm_ext, rs, rt, rd, shamt, funcion, flush, hold,
    input  ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite,
           ex_jump, ex_shiftC, ex_ALUOp, ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm_ext,
           ex_rs, ex_rt, ex_rd, ex_shamt, ex_funcion, ctrl_enable, pc_write, if_id_write, stall_count
  );
  modport slave (
    input  RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, jump, shiftC, ALUOp,
           pc_plus4, read_data1, read_data2, imm_ext, rs, rt, rd, shamt, funcion, flush, hold,
    output ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite,
           ex_jump, ex_shiftC, ex_ALUOp, ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm_ext,
           ex_rs, ex_rt, ex_rd, ex_shamt, ex_funcion, ctrl_enable, pc_write, if_id_write, stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection and saturating stall counter
module id_ex_stage (
  input logic clk,
  input logic reset,
  id_ex_if.slave b
);
  logic hazard;
  assign hazard = b.ex_MemRead && b.ex_rt != 5'd0 && (b.ex_rt == b.rs || b.ex_rt == b.rt);
  assign b.ctrl_enable = !hazard;
  assign b.pc_write = !hazard && !b.hold;
  assign b.if_id_write = !hazard && !b.hold;
  // flush outranks hold so a redirect bubble is never lost; data still loads on flush
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {b.ex_RegDst, b.ex_Branch, b.ex_MemRead, b.ex_MemtoReg, b.ex_MemWrite, b.ex_ALUSrc,
       b.ex_RegWrite, b.ex_jump, b.ex_shiftC, b.ex_ALUOp} <= '0;
      {b.ex_pc_plus4, b.ex_read_data1, b.ex_read_data2, b.ex_imm_ext,
       b.ex_rs, b.ex_rt, b.ex_rd, b.ex_shamt, b.ex_funcion} <= '0;
      b.stall_count <= '0;
    end else begin
      if (b.flush || !b.hold) begin
        {b.ex_RegDst, b.ex_Branch, b.ex_MemRead, b.ex_MemtoReg, b.ex_MemWrite, b.ex_ALUSrc,
         b.ex_RegWrite, b.ex_jump, b.ex_shiftC, b.ex_ALUOp} <= b.flush ? 11'd0 :
          {b.RegDst, b.Branch, b.MemRead, b.MemtoReg, b.MemWrite, b.ALUSrc,
           b.RegWrite, b.jump, b.shiftC, b.ALUOp};
        {b.ex_pc_plus4, b.ex_read_data1, b.ex_read_data2, b.ex_imm_ext,
         b.ex_rs, b.ex_rt, b.ex_rd, b.ex_shamt, b.ex_funcion} <=
          {b.pc_plus4, b.read_data1, b.read_data2, b.imm_ext, b.rs, b.rt, b.rd, b.shamt, b.funcion};
      end
      if (hazard && !b.hold && b.stall_count != 16'hffff) b.stall_count <= b.stall_count + 16'd1;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven vectors with a scoreboard queue, plus saturation and async reset sequences
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic reset;
  int tests = 0;
  int fails = 0;
  id_ex_if bus ();
  id_ex_stage dut (.clk(clk), .reset(reset), .b(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [10:0] ctl;
    logic [31:0] d1;
    logic [4:0] rs, rt;
    logic f, h, ce, pw;
    logic [10:0] ectl;
    logic [31:0] ed1;
    logic [4:0] ers, ert;
    logic [15:0] est;
  } vec_t;
  typedef struct {
    logic [10:0] ctl;
    logic [153:0] dat;
    logic [15:0] st;
  } exp_t;
  vec_t vs[12];
  exp_t q[$];
  exp_t e;
  function automatic logic [153:0] mk(logic [31:0] d, logic [4:0] s, logic [4:0] t);
    return {d + 32'd4, d, ~d, d ^ 32'hA5A5_0F0F, s, t, s ^ t, s + t, d[5:0]};
  endfunction
  function automatic logic [10:0] got_ctl();
    return {bus.ex_RegDst, bus.ex_Branch, bus.ex_MemRead, bus.ex_MemtoReg, bus.ex_MemWrite,
            bus.ex_ALUSrc, bus.ex_RegWrite, bus.ex_jump, bus.ex_shiftC, bus.ex_ALUOp};
  endfunction
  function automatic logic [153:0] got_dat();
    return {bus.ex_pc_plus4, bus.ex_read_data1, bus.ex_read_data2, bus.ex_imm_ext,
            bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_shamt, bus.ex_funcion};
  endfunction
  task automatic chk(input string n, input logic [159:0] got, input logic [159:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic drive(input logic [10:0] c, input logic [31:0] d, input logic [4:0] s,
                       input logic [4:0] t, input logic f, input logic h);
    {bus.RegDst, bus.Branch, bus.MemRead, bus.MemtoReg, bus.MemWrite, bus.ALUSrc,
     bus.RegWrite, bus.jump, bus.shiftC, bus.ALUOp} = c;
    {bus.pc_plus4, bus.read_data1, bus.read_data2, bus.imm_ext,
     bus.rs, bus.rt, bus.rd, bus.shamt, bus.funcion} = mk(d, s, t);
    bus.flush = f;
    bus.hold = h;
  endtask
  initial begin
    // R-type = 11'h412, LW = 11'h1B0 (bit order RegDst..shiftC, ALUOp)
    vs[0]  = '{11'h412, 32'h5,  5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1, 11'h412, 32'h5,  5'd1, 5'd2, 16'd0};
    vs[1]  = '{11'h1B0, 32'h8,  5'd3, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 11'h1B0, 32'h8,  5'd3, 5'd5, 16'd0};
    vs[2]  = '{11'h000, 32'h9,  5'd5, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 32'h9,  5'd5, 5'd6, 16'd1};
    vs[3]  = '{11'h412, 32'hA,  5'd5, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1, 11'h412, 32'hA,  5'd5, 5'd6, 16'd1};
    vs[4]  = '{11'h1B0, 32'hB,  5'd1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 11'h1B0, 32'hB,  5'd1, 5'd0, 16'd1};
    vs[5]  = '{11'h412, 32'hC,  5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 11'h412, 32'hC,  5'd0, 5'd0, 16'd1};
    vs[6]  = '{11'h412, 32'hD,  5'd7, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 11'h000, 32'hD,  5'd7, 5'd8, 16'd1};
    vs[7]  = '{11'h412, 32'hE,  5'd9, 5'd10, 1'b0, 1'b1, 1'b1, 1'b0, 11'h000, 32'hD, 5'd7, 5'd8, 16'd1};
    vs[8]  = '{11'h1B0, 32'hF,  5'd1, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 11'h1B0, 32'hF,  5'd1, 5'd4, 16'd1};
    vs[9]  = '{11'h000, 32'h10, 5'd2, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 11'h1B0, 32'hF,  5'd1, 5'd4, 16'd1};
    vs[10] = '{11'h1B0, 32'h11, 5'd4, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000, 32'h11, 5'd4, 5'd3, 16'd2};
    vs[11] = '{11'h412, 32'h12, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1, 11'h412, 32'h12, 5'd1, 5'd2, 16'd2};
    reset = 1'b1;
    drive(11'h7FF, 32'hDEAD_BEEF, 5'd3, 5'd3, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_ctl", 160'(got_ctl()), 160'd0);
    chk("reset_data", 160'(got_dat()), 160'd0);
    chk("reset_stall", 160'(bus.stall_count), 160'd0);
    chk("reset_enables", 160'({bus.ctrl_enable, bus.pc_write, bus.if_id_write}), 160'(3'b111));
    foreach (vs[i]) begin
      drive(vs[i].ctl, vs[i].d1, vs[i].rs, vs[i].rt, vs[i].f, vs[i].h);
      q.push_back('{vs[i].ectl, mk(vs[i].ed1, vs[i].ers, vs[i].ert), vs[i].est});
      #1;
      chk($sformatf("v%0d_ctrl_enable", i), 160'(bus.ctrl_enable), 160'(vs[i].ce));
      chk($sformatf("v%0d_pc_write", i), 160'(bus.pc_write), 160'(vs[i].pw));
      chk($sformatf("v%0d_if_id_write", i), 160'(bus.if_id_write), 160'(vs[i].pw));
      @(negedge clk);
      e = q.pop_front();
      chk($sformatf("v%0d_ex_ctl", i), 160'(got_ctl()), 160'(e.ctl));
      chk($sformatf("v%0d_ex_data", i), 160'(got_dat()), 160'(e.dat));
      chk($sformatf("v%0d_stall", i), 160'(bus.stall_count), 160'(e.st));
    end
    // keep a load with rt=rs=5 in EX every cycle so the hazard persists
    drive(11'h1B0, 32'h0, 5'd5, 5'd5, 1'b0, 1'b0);
    repeat (65540) @(posedge clk);
    @(negedge clk);
    chk("sat_stall", 160'(bus.stall_count), 160'(16'hFFFF));
    chk("sat_hazard", 160'({bus.ctrl_enable, bus.pc_write}), 160'(2'b00));
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("sat_hold_ffff", 160'(bus.stall_count), 160'(16'hFFFF));
    reset = 1'b1;
    #1;
    chk("async_reset_stall", 160'(bus.stall_count), 160'd0);
    chk("async_reset_ctl", 160'(got_ctl()), 160'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(11'h000, 32'h0, 5'd5, 5'd5, 1'b0, 1'b1);
    #1;
    chk("post_reset_hold", 160'({bus.ctrl_enable, bus.pc_write, bus.if_id_write}), 160'(3'b100));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between decode and execute for the 5-stage MIPS core, with integrated load-use hazard detection. It latches the decoded control bits and operands from the decode stage and presents them to the execute stage one cycle later. It detects a load in EX whose destination feeds the instruction now in ID, and then drives the decoder's enable low so a bubble is inserted. It also freezes the PC and IF/ID for that cycle, supports flush on branch/jump redirect and a global hold, and counts hazard stalls.

## Interface
- No parameters; datapath 32-bit, register index 5-bit (fixed).
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, jump, shiftC  input  1 each  decoded control bits from the decoder
- ALUOp  input  2  decoded ALU class
- pc_plus4, read_data1, read_data2, imm_ext  input  32 each  decode-stage values
- rs, rt, rd, shamt  input  5 each  instruction fields of the ID instruction
- funcion  input  6  function field of the ID instruction
- flush  input  1  squash the ID instruction (branch/jump redirect)
- hold  input  1  freeze this register (downstream busy)
- ex_* outputs (ex_RegDst … ex_shiftC 1 each, ex_ALUOp 2, ex_pc_plus4/ex_read_data1/ex_read_data2/ex_imm_ext 32, ex_rs/ex_rt/ex_rd/ex_shamt 5, ex_funcion 6)  output  registered copies for EX
- ctrl_enable  output  1  enable to the decoder; 0 forces a bubble
- pc_write  output  1  PC update enable
- if_id_write  output  1  IF/ID register update enable
- stall_count  output  16  saturating count of load-use stall cycles

## Operation
- Hazard, combinational from registered state: hazard = ex_MemRead & (ex_rt != 0) & ((ex_rt == rs) | (ex_rt == rt)).
- ctrl_enable = ~hazard. pc_write = ~hazard & ~hold. if_id_write = ~hazard & ~hold.
- Register update priority on each rising clk:
  - reset: all ex_* and stall_count go to 0.
  - flush: all ex_* control bits go to 0, including ex_ALUOp = 2'b00. Data fields load normally.
  - hold: all ex_* retain their values.
  - otherwise: all ex_* load their inputs.
- During a hazard the decoder outputs zeros because of ctrl_enable=0. The register therefore latches a bubble naturally, with no special case. The next cycle ex_MemRead=0, so the hazard lasts exactly one cycle per load.
- flush and hazard in the same cycle: flush rule applies and the register latches a bubble. pc_write and if_id_write still follow the hazard equation.
- flush and hold in the same cycle: flush wins, so a redirect is never lost.
- stall_count increments by 1 on each clk where hazard & ~hold & ~reset. It saturates at 16'hFFFF and never wraps.
- reset asserted mid-operation clears everything immediately, independent of clk.

## Timing
- Latency: ID inputs are visible on ex_* one clock after the edge that captures them.
- Reset values: every ex_* output is 0 and stall_count is 0.
- Because ex_MemRead=0 after reset, ctrl_enable=1, pc_write=~hold and if_id_write=~hold.
- hazard, ctrl_enable, pc_write and if_id_write are combinational within the cycle. They depend on ex_* (registered) and on rs, rt and hold (current inputs).
- No path exists from control inputs to ctrl_enable, so there is no combinational loop through the decoder.
- The effect of flush or hold is seen at the next rising edge only.

## Test plan
- Reset: hold reset=1 with arbitrary inputs, then release → all ex_*=0, stall_count=0, ctrl_enable=1, pc_write=1, if_id_write=1.
- Normal load: R-type inputs (RegDst=1, RegWrite=1, ALUOp=2'b10, read_data1=32'h0000_0005) with no flush or hold → after 1 clk ex_RegDst=1, ex_ALUOp=2'b10, ex_read_data1=32'h5.
- Load-use: latch an LW with rt=5, then present rs=5 → ctrl_enable=0, pc_write=0, if_id_write=0. With decoder zeros applied, the next clk gives ex_MemRead=0 and ctrl_enable=1, and stall_count=1.
- No false hazard: LW with rt=0 latched, then rs=0 and rt=0 → ctrl_enable stays 1 and stall_count is unchanged.
- Flush vs hold: latch RegWrite=1 with flush=1 and hold=1 on the same edge → ex_RegWrite=0 and ex_ALUOp=2'b00. With hold=1 alone the next edge → all ex_* unchanged and pc_write=0.
- Saturation: force 65 536 hazard cycles → stall_count reaches 16'hFFFF and stays there on further hazards. Asserting reset mid-count → stall_count=0 asynchronously.
